id_ex_stage: RTL and testbench

Decode-to-execute pipeline register that sits directly upstream of the ALU. It captures one decoded instruction per handshake and drives the ALU operand and control inputs (A0, A1, ALU_con). It resolves operand hazards by forwarding from the EX/MEM and MEM/WB stages, and stalls on load-use dependencies. Store data and writeback control pass through to the memory stage.

---
 rtl/id_ex_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register sitting directly in front of the ALU.
// It holds one decoded instruction and presents the ALU operands (A0, A1)
// and the ALU opcode (ALU_con). Store data and writeback control travel
// alongside to the memory stage.
//
// Build option:
//   ID_EX_FORWARD_EN  defined   : operands are forwarded from EX/MEM and
//                                 MEM/WB, and the stage stalls only on a
//                                 load-use dependency.
//                     undefined : no forwarding muxes. The stage stalls
//                                 while any older in-flight writer (EX/MEM
//                                 or MEM/WB) targets rs1 or rs2.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. valid never depends on ready. Once valid
// is raised, the offered payload is held until the transfer. The single
// exception is the output side: while a hazard is active, out_valid drops
// and the stored entry is held unchanged.
//
// Ports:
//   clk, reset          clock (rising edge); asynchronous active-high reset
//   in_valid/in_ready   decode-side handshake
//   in_rs1_data/rs2     register-file operand values
//   in_imm              sign-extended immediate
//   in_rs1/rs2/rd       source and destination register addresses
//   in_alu_con          ALU opcode, passed through unmodified
//   in_alu_src          1: A1 takes the immediate
//   in_ctrl             {reg_write, mem_read, mem_write}
//   flush               drops the held entry and any incoming instruction
//   out_valid/out_ready execute-side handshake
//   A0, A1, ALU_con     ALU operands and opcode
//   out_store_data      forwarded rs2 value for stores
//   out_rd, out_ctrl    destination address and control for later stages
//   exmem_*             EX/MEM stage destination, control and result
//   memwb_*             MEM/WB stage destination, write enable and value
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [3:0]        in_alu_con,
    input  logic              in_alu_src,
    input  logic [2:0]        in_ctrl,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A0,
    output logic [DATA_W-1:0] A1,
    output logic [3:0]        ALU_con,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_rd,
    output logic [2:0]        out_ctrl,

    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [2:0]        exmem_ctrl,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_result
);

    // Bit positions inside a {reg_write, mem_read, mem_write} control word.
    localparam int CTRL_REG_WRITE = 2;
    localparam int CTRL_MEM_READ  = 1;

    // -------------------------------------------------------------------------
    // Stored entry
    // -------------------------------------------------------------------------
    logic              full_q,     full_d;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [REG_AW-1:0] rs1_q,      rs1_d;
    logic [REG_AW-1:0] rs2_q,      rs2_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [3:0]        alu_con_q,  alu_con_d;
    logic              alu_src_q,  alu_src_d;
    logic [2:0]        ctrl_q,     ctrl_d;

    // -------------------------------------------------------------------------
    // Hazard detection and operand selection
    // -------------------------------------------------------------------------
    logic              hazard;
    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;
    logic              accept;
    logic              dequeue;

`ifdef ID_EX_FORWARD_EN
    logic exmem_is_load;
    logic exmem_is_alu_write;
    logic unused_inputs;

    // A load in EX/MEM has no data yet; it is only usable one stage later.
    assign exmem_is_load      = exmem_ctrl[CTRL_REG_WRITE] && exmem_ctrl[CTRL_MEM_READ];
    assign exmem_is_alu_write = exmem_ctrl[CTRL_REG_WRITE] && !exmem_ctrl[CTRL_MEM_READ];

    // x0 is hard-wired, so a load targeting it never creates a dependency.
    assign hazard = full_q && exmem_is_load && (exmem_rd != '0) &&
                    ((exmem_rd == rs1_q) || (exmem_rd == rs2_q));

    // The younger producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (rs1_q != '0) begin
            if (exmem_is_alu_write && (exmem_rd == rs1_q)) begin
                fwd_rs1 = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == rs1_q)) begin
                fwd_rs1 = memwb_result;
            end
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (rs2_q != '0) begin
            if (exmem_is_alu_write && (exmem_rd == rs2_q)) begin
                fwd_rs2 = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == rs2_q)) begin
                fwd_rs2 = memwb_result;
            end
        end
    end

    // The mem_write bit of EX/MEM has no bearing on operand hazards.
    assign unused_inputs = exmem_ctrl[0];
`else
    logic rs1_busy;
    logic rs2_busy;
    logic unused_inputs;

    // Without bypassing, wait until every older writer of a source has
    // retired into the register file.
    always_comb begin
        rs1_busy = 1'b0;
        if (rs1_q != '0) begin
            rs1_busy = (exmem_ctrl[CTRL_REG_WRITE] && (exmem_rd == rs1_q)) ||
                       (memwb_reg_write && (memwb_rd == rs1_q));
        end
    end

    always_comb begin
        rs2_busy = 1'b0;
        if (rs2_q != '0) begin
            rs2_busy = (exmem_ctrl[CTRL_REG_WRITE] && (exmem_rd == rs2_q)) ||
                       (memwb_reg_write && (memwb_rd == rs2_q));
        end
    end

    assign hazard  = full_q && (rs1_busy || rs2_busy);
    assign fwd_rs1 = rs1_data_q;
    assign fwd_rs2 = rs2_data_q;

    // Result buses and the remaining control bits only matter for bypassing.
    assign unused_inputs = ^{exmem_ctrl[1:0], exmem_result, memwb_result};
`endif

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign out_valid = full_q && !hazard;
    assign dequeue   = out_valid && out_ready;
    // Pass-through: a new entry may land on the same edge the old one leaves.
    assign in_ready  = !full_q || dequeue;
    assign accept    = in_valid && in_ready && !flush;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        full_d     = full_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        alu_con_d  = alu_con_q;
        alu_src_d  = alu_src_q;
        ctrl_d     = ctrl_q;

        if (flush) begin
            // Flush beats both accept and dequeue; fields keep stale values
            // but are masked by full_q.
            full_d = 1'b0;
        end else if (accept) begin
            full_d     = 1'b1;
            rs1_data_d = in_rs1_data;
            rs2_data_d = in_rs2_data;
            imm_d      = in_imm;
            rs1_d      = in_rs1;
            rs2_d      = in_rs2;
            rd_d       = in_rd;
            alu_con_d  = in_alu_con;
            alu_src_d  = in_alu_src;
            ctrl_d     = in_ctrl;
        end else if (dequeue) begin
            full_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q     <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_con_q  <= '0;
            alu_src_q  <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            full_q     <= full_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            alu_con_q  <= alu_con_d;
            alu_src_q  <= alu_src_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign A0             = fwd_rs1;
    assign A1             = alu_src_q ? imm_q : fwd_rs2;
    assign ALU_con        = alu_con_q;
    assign out_store_data = fwd_rs2;
    assign out_rd         = rd_q;
    assign out_ctrl       = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. Directed scenario tasks check the
// reset state, forwarding, load-use stall, backpressure, flush and the x0
// guard; a random back-to-back stream is checked against an expected queue.
// Expectations that differ between the forwarding and non-forwarding builds
// follow the ID_EX_FORWARD_EN macro.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int EXP_W  = 3 * DATA_W + 4 + REG_AW + 3;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
    logic [3:0]        in_alu_con;
    logic              in_alu_src;
    logic [2:0]        in_ctrl;
    logic              flush;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] A0, A1, out_store_data;
    logic [3:0]        ALU_con;
    logic [REG_AW-1:0] out_rd;
    logic [2:0]        out_ctrl;
    logic [REG_AW-1:0] exmem_rd, memwb_rd;
    logic [2:0]        exmem_ctrl;
    logic [DATA_W-1:0] exmem_result, memwb_result;
    logic              memwb_reg_write;

    int errors = 0;
    int checks = 0;
    logic [EXP_W-1:0] exp_q[$];

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_con(in_alu_con), .in_alu_src(in_alu_src), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .A0(A0), .A1(A1), .ALU_con(ALU_con), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_ctrl(out_ctrl),
        .exmem_rd(exmem_rd), .exmem_ctrl(exmem_ctrl), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result)
    );

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        in_valid = 1'b0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_alu_con = '0; in_alu_src = 1'b0;
        in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
        exmem_rd = '0; exmem_ctrl = '0; exmem_result = '0;
        memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                               input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] d1,
                               input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] imm,
                               input logic [3:0] con, input logic src, input logic [2:0] ctrl);
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
        in_alu_con = con; in_alu_src = src; in_ctrl = ctrl;
        in_valid = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (A0 !== 32'h0) begin errors++; $display("FAIL rst_a0: got %h want 0", A0); end
        checks++; if (A1 !== 32'h0) begin errors++; $display("FAIL rst_a1: got %h want 0", A1); end
        checks++; if (ALU_con !== 4'h0) begin errors++; $display("FAIL rst_alu_con: got %h want 0", ALU_con); end
        checks++; if (out_store_data !== 32'h0) begin errors++; $display("FAIL rst_store: got %h want 0", out_store_data); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d want 0", out_rd); end
        checks++; if (out_ctrl !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b want 000", out_ctrl); end
        step();
        reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_first_accept();
        drive_entry(5'd1, 5'd2, 5'd6, 32'd5, 32'd7, 32'd0, 4'b0010, 1'b0, 3'b100);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL acc_in_ready_empty: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL acc_out_valid: got %b want 1", out_valid); end
        checks++; if (A0 !== 32'd5) begin errors++; $display("FAIL acc_a0: got %h want 5", A0); end
        checks++; if (A1 !== 32'd7) begin errors++; $display("FAIL acc_a1: got %h want 7", A1); end
        checks++; if (ALU_con !== 4'b0010) begin errors++; $display("FAIL acc_alu_con: got %b want 0010", ALU_con); end
        checks++; if (out_store_data !== 32'd7) begin errors++; $display("FAIL acc_store: got %h want 7", out_store_data); end
        checks++; if (out_rd !== 5'd6) begin errors++; $display("FAIL acc_rd: got %0d want 6", out_rd); end
        checks++; if (out_ctrl !== 3'b100) begin errors++; $display("FAIL acc_ctrl: got %b want 100", out_ctrl); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL acc_in_ready_full: got %b want 0", in_ready); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_exmem_forward();
        drive_entry(5'd3, 5'd0, 5'd8, 32'h11, 32'h0, 32'h4, 4'b0010, 1'b1, 3'b100);
        step();
        in_valid = 1'b0;
        exmem_rd = 5'd3; exmem_ctrl = 3'b100; exmem_result = 32'h20;
        #1;
        checks++; if (out_valid !== FWD) begin errors++; $display("FAIL exfwd_valid: got %b want %b", out_valid, FWD); end
        checks++; if (A0 !== (FWD ? 32'h20 : 32'h11)) begin errors++; $display("FAIL exfwd_a0: got %h want %h", A0, FWD ? 32'h20 : 32'h11); end
        checks++; if (A1 !== 32'h4) begin errors++; $display("FAIL exfwd_a1_imm: got %h want 4", A1); end
        step();
        memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 32'h99;
        #1;
        checks++; if (A0 !== (FWD ? 32'h20 : 32'h11)) begin errors++; $display("FAIL exfwd_priority: got %h want %h", A0, FWD ? 32'h20 : 32'h11); end
        checks++; if (out_valid !== FWD) begin errors++; $display("FAIL exfwd_both_valid: got %b want %b", out_valid, FWD); end
        step();
        exmem_ctrl = 3'b000;
        #1;
        checks++; if (A0 !== (FWD ? 32'h99 : 32'h11)) begin errors++; $display("FAIL wbfwd_a0: got %h want %h", A0, FWD ? 32'h99 : 32'h11); end
        checks++; if (out_valid !== FWD) begin errors++; $display("FAIL wbfwd_valid: got %b want %b", out_valid, FWD); end
        step();
        memwb_reg_write = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nofwd_valid: got %b want 1", out_valid); end
        checks++; if (A0 !== 32'h11) begin errors++; $display("FAIL nofwd_a0: got %h want 11", A0); end
        set_idle();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_load_use();
        drive_entry(5'd1, 5'd4, 5'd9, 32'h10, 32'h44, 32'h0, 4'b0100, 1'b0, 3'b100);
        step();
        // A second instruction is offered during the stall and must not land.
        drive_entry(5'd2, 5'd2, 5'd12, 32'h1, 32'h2, 32'h3, 4'b0001, 1'b0, 3'b100);
        exmem_rd = 5'd4; exmem_ctrl = 3'b110; exmem_result = 32'hDEAD;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_stall_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready: got %b want 0", in_ready); end
        step();
        in_valid = 1'b0;
        exmem_rd = 5'd0; exmem_ctrl = 3'b000;
        memwb_rd = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'hAB;
        #1;
        checks++; if (out_valid !== FWD) begin errors++; $display("FAIL lu_release_valid: got %b want %b", out_valid, FWD); end
        checks++; if (A1 !== (FWD ? 32'hAB : 32'h44)) begin errors++; $display("FAIL lu_a1: got %h want %h", A1, FWD ? 32'hAB : 32'h44); end
        checks++; if (out_store_data !== (FWD ? 32'hAB : 32'h44)) begin errors++; $display("FAIL lu_store: got %h want %h", out_store_data, FWD ? 32'hAB : 32'h44); end
        checks++; if (out_rd !== 5'd9) begin errors++; $display("FAIL lu_held_rd: got %0d want 9", out_rd); end
        checks++; if (A0 !== 32'h10) begin errors++; $display("FAIL lu_a0: got %h want 10", A0); end
        memwb_reg_write = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_clear_valid: got %b want 1", out_valid); end
        checks++; if (A1 !== 32'h44) begin errors++; $display("FAIL lu_clear_a1: got %h want 44", A1); end
        step();
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_drained: got %b want 0", out_valid); end
        set_idle();
    endtask

    task automatic test_backpressure();
        drive_entry(5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h3, 4'b0001, 1'b0, 3'b100);
        step();
        drive_entry(5'd10, 5'd11, 5'd13, 32'hA, 32'hB, 32'hC, 4'b0000, 1'b1, 3'b010);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b want 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b want 0", i, in_ready); end
            checks++; if (out_rd !== 5'd7) begin errors++; $display("FAIL bp_rd_%0d: got %0d want 7", i, out_rd); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_passthru_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_nobubble_valid: got %b want 1", out_valid); end
        checks++; if (out_rd !== 5'd13) begin errors++; $display("FAIL bp_new_rd: got %0d want 13", out_rd); end
        checks++; if (A0 !== 32'hA) begin errors++; $display("FAIL bp_new_a0: got %h want a", A0); end
        checks++; if (A1 !== 32'hC) begin errors++; $display("FAIL bp_new_a1: got %h want c", A1); end
        checks++; if (out_ctrl !== 3'b010) begin errors++; $display("FAIL bp_new_ctrl: got %b want 010", out_ctrl); end
        out_ready = 1'b1;
        step();
        set_idle();
    endtask

    task automatic test_flush();
        drive_entry(5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 32'h0, 4'b0010, 1'b0, 3'b100);
        step();
        drive_entry(5'd3, 5'd4, 5'd10, 32'h3, 32'h4, 32'h0, 4'b0010, 1'b0, 3'b100);
        flush = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fl_before: got %b want 1", out_valid); end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_killed: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped: got %b want 0", out_valid); end
        // Flush on an empty stage also drops the incoming instruction.
        drive_entry(5'd3, 5'd4, 5'd11, 32'h3, 32'h4, 32'h0, 4'b0010, 1'b0, 3'b100);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_empty_drop: got %b want 0", out_valid); end
        set_idle();
    endtask

    task automatic test_rd0_guard();
        drive_entry(5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'hFFFF_FFF0, 4'b1110, 1'b1, 3'b100);
        step();
        in_valid = 1'b0;
        exmem_rd = 5'd0; exmem_ctrl = 3'b100; exmem_result = 32'h55;
        memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'h66;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %b want 1", out_valid); end
        checks++; if (A0 !== 32'h0) begin errors++; $display("FAIL x0_a0: got %h want 0", A0); end
        checks++; if (A1 !== 32'hFFFF_FFF0) begin errors++; $display("FAIL x0_a1: got %h want fffffff0", A1); end
        checks++; if (out_store_data !== 32'h0) begin errors++; $display("FAIL x0_store: got %h want 0", out_store_data); end
        checks++; if (ALU_con !== 4'b1110) begin errors++; $display("FAIL x0_alu_con: got %b want 1110", ALU_con); end
        exmem_ctrl = 3'b110;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL x0_no_loaduse: got %b want 1", out_valid); end
        set_idle();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        drive_entry(5'd2, 5'd4, 5'd11, 32'h2, 32'h4, 32'h0, 4'b0010, 1'b0, 3'b100);
        step();
        in_valid = 1'b0;
        exmem_rd = 5'd4; exmem_ctrl = 3'b110;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rs_stalled: got %b want 0", in_ready); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rs_async_ready: got %b want 1", in_ready); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL rs_async_rd: got %0d want 0", out_rd); end
        reset = 1'b0;
        exmem_ctrl = 3'b000;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_discarded: got %b want 0", out_valid); end
        set_idle();
    endtask

    task automatic test_back_to_back();
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] want;
        int popped;
        int budget;
        popped = 0;
        set_idle();
        for (int c = 0; c < 300; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            in_rs1      = 5'($urandom_range(0, 31));
            in_rs2      = 5'($urandom_range(0, 31));
            in_rd       = 5'($urandom_range(0, 31));
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            in_imm      = $urandom;
            in_alu_con  = 4'($urandom_range(0, 15));
            in_alu_src  = 1'($urandom_range(0, 1));
            in_ctrl     = 3'($urandom_range(0, 7));
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected_output: got rd=%0d want none", out_rd);
                end else begin
                    got  = {A0, A1, ALU_con, out_store_data, out_rd, out_ctrl};
                    want = exp_q.pop_front();
                    popped++;
                    if (got !== want) begin errors++; $display("FAIL b2b_data: got %h want %h", got, want); end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({in_rs1_data, (in_alu_src ? in_imm : in_rs2_data), in_alu_con,
                                 in_rs2_data, in_rd, in_ctrl});
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (out_valid && budget < 10) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL b2b_drain_unexpected: got rd=%0d want none", out_rd);
            end else begin
                got  = {A0, A1, ALU_con, out_store_data, out_rd, out_ctrl};
                want = exp_q.pop_front();
                popped++;
                if (got !== want) begin errors++; $display("FAIL b2b_drain_data: got %h want %h", got, want); end
            end
            step();
            budget++;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_timeout: got %b want 0", out_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
        checks++; if (popped < 50) begin errors++; $display("FAIL b2b_throughput: got %0d want >=50", popped); end
        set_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_accept();
        test_exmem_forward();
        test_load_use();
        test_backpressure();
        test_flush();
        test_rd0_guard();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
